// File: rtl/miter_output_monitor.sv
`default_nettype none
// ============================================================================
// Module      : miter_output_monitor
// Description : Compares golden/revised netlist output vectors, counts
//               vectors and mismatches, captures the first failure and
//               compresses both streams into MISR signatures.
// Revision    : 1.0 - initial release
// ============================================================================
module miter_output_monitor #(
  parameter int             W     = 9,
  parameter int             CNT_W = 16,
  parameter logic [W-1:0]   POLY  = 9'h011,
  parameter logic [W-1:0]   SEED  = 9'h000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [W-1:0]     golden,
  input  logic [W-1:0]     revised,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] mism_cnt,
  output logic [CNT_W-1:0] first_idx,
  output logic [W-1:0]     first_diff,
  output logic [W-1:0]     sig_golden,
  output logic [W-1:0]     sig_revised,
  output logic             sig_equal
);

  localparam logic [1:0]       c_st_idle = 2'd0;
  localparam logic [1:0]       c_st_run  = 2'd1;
  localparam logic [1:0]       c_st_done = 2'd2;
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_fail;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [CNT_W-1:0] r_mism_cnt;
  logic [CNT_W-1:0] r_first_idx;
  logic [W-1:0]     r_first_diff;
  logic [W-1:0]     r_sig_golden;
  logic [W-1:0]     r_sig_revised;

  logic w_accept;
  logic w_mismatch;

  function automatic logic [W-1:0] f_misr_next(input logic [W-1:0] sig,
                                               input logic [W-1:0] data);
    return {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ data;
  endfunction

  // A vector arriving together with start belongs to no run and is dropped.
  assign w_accept   = (r_state == c_st_run) && in_valid && !start;
  assign w_mismatch = (golden != revised);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_st_idle;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
      r_vec_cnt     <= '0;
      r_mism_cnt    <= '0;
      r_first_idx   <= '0;
      r_first_diff  <= '0;
      r_sig_golden  <= '0;
      r_sig_revised <= '0;
    end else if (start) begin
      r_state       <= c_st_run;
      r_busy        <= 1'b1;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
      r_vec_cnt     <= '0;
      r_mism_cnt    <= '0;
      r_first_idx   <= '0;
      r_first_diff  <= '0;
      r_sig_golden  <= SEED;
      r_sig_revised <= SEED;
    end else begin
      if ((r_state == c_st_run) && stop) begin
        r_state <= c_st_done;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
      if (w_accept) begin
        if (r_vec_cnt != c_cnt_max) begin
          r_vec_cnt <= r_vec_cnt + CNT_W'(1);
        end
        r_sig_golden  <= f_misr_next(r_sig_golden, golden);
        r_sig_revised <= f_misr_next(r_sig_revised, revised);
        if (w_mismatch) begin
          if (r_mism_cnt != c_cnt_max) begin
            r_mism_cnt <= r_mism_cnt + CNT_W'(1);
          end
          r_fail <= 1'b1;
          if (!r_fail) begin
            r_first_idx  <= r_vec_cnt;
            r_first_diff <= golden ^ revised;
          end
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign fail        = r_fail;
  assign vec_cnt     = r_vec_cnt;
  assign mism_cnt    = r_mism_cnt;
  assign first_idx   = r_first_idx;
  assign first_diff  = r_first_diff;
  assign sig_golden  = r_sig_golden;
  assign sig_revised = r_sig_revised;
  assign sig_equal   = r_done && (r_sig_golden == r_sig_revised);

endmodule
`default_nettype wire

// File: tb/tb_miter_output_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_miter_output_monitor
// Description : Scoreboard bench for miter_output_monitor (CNT_W=16 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_miter_output_monitor;

  localparam int         W       = 9;
  localparam logic [8:0] C_SEED  = 9'h000;

  logic clk = 1'b0;
  logic rst_n, start, stop, in_valid;
  logic [W-1:0] golden, revised;

  logic          busy, done, fail, sig_equal;
  logic [15:0]   vec_cnt, mism_cnt, first_idx;
  logic [W-1:0]  first_diff, sig_golden, sig_revised;

  logic          busy4, done4, fail4, sig_equal4;
  logic [3:0]    vec_cnt4, mism_cnt4, first_idx4;
  logic [W-1:0]  first_diff4, sig_golden4, sig_revised4;

  always #5 clk = ~clk;

  miter_output_monitor #(.W(W), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .golden(golden), .revised(revised), .busy(busy), .done(done), .fail(fail),
    .vec_cnt(vec_cnt), .mism_cnt(mism_cnt), .first_idx(first_idx),
    .first_diff(first_diff), .sig_golden(sig_golden), .sig_revised(sig_revised),
    .sig_equal(sig_equal)
  );

  miter_output_monitor #(.W(W), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .in_valid(in_valid),
    .golden(golden), .revised(revised), .busy(busy4), .done(done4), .fail(fail4),
    .vec_cnt(vec_cnt4), .mism_cnt(mism_cnt4), .first_idx(first_idx4),
    .first_diff(first_diff4), .sig_golden(sig_golden4), .sig_revised(sig_revised4),
    .sig_equal(sig_equal4)
  );

  typedef struct {
    logic        busy, done, fail, sig_equal;
    logic [31:0] vec, mism, fidx, vec4, mism4, fidx4;
    logic [8:0]  fdiff, sg, sr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state; counters are unbounded and saturated on output.
  int         m_st;
  int         m_vec, m_mism, m_fidx;
  logic       m_fail;
  logic [8:0] m_fdiff, m_sg, m_sr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [8:0] misr(input logic [8:0] s, input logic [8:0] d);
    logic [9:0] t;
    t = {s, 1'b0};
    if (t[9]) t = t ^ 10'h211;
    return t[8:0] ^ d;
  endfunction

  function automatic logic [31:0] sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_vec = 0; m_mism = 0; m_fidx = 0;
    m_fail = 0; m_fdiff = 0; m_sg = 0; m_sr = 0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.busy = (m_st == 1); e.done = (m_st == 2); e.fail = m_fail;
    e.sig_equal = (m_st == 2) && (m_sg == m_sr);
    e.vec  = sat(m_vec, 65535); e.mism  = sat(m_mism, 65535); e.fidx  = sat(m_fidx, 65535);
    e.vec4 = sat(m_vec, 15);    e.mism4 = sat(m_mism, 15);    e.fidx4 = sat(m_fidx, 15);
    e.fdiff = m_fdiff; e.sg = m_sg; e.sr = m_sr;
    q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = q.pop_front();
    check("busy", busy, e.busy);
    check("done", done, e.done);
    check("fail", fail, e.fail);
    check("vec_cnt", vec_cnt, e.vec);
    check("mism_cnt", mism_cnt, e.mism);
    check("first_idx", first_idx, e.fidx);
    check("first_diff", first_diff, e.fdiff);
    check("sig_golden", sig_golden, e.sg);
    check("sig_revised", sig_revised, e.sr);
    check("sig_equal", sig_equal, e.sig_equal);
    check("vec_cnt4", vec_cnt4, e.vec4);
    check("mism_cnt4", mism_cnt4, e.mism4);
    check("first_idx4", first_idx4, e.fidx4);
    check("done4", done4, e.done);
  endtask

  task automatic step(input bit s, input bit p, input bit v,
                      input logic [8:0] g, input logic [8:0] r);
    bit acc;
    @(negedge clk);
    start = s; stop = p; in_valid = v; golden = g; revised = r;
    acc = (m_st == 1) && v && !s;
    if (s) begin
      m_st = 1; m_vec = 0; m_mism = 0; m_fidx = 0;
      m_fail = 0; m_fdiff = 0; m_sg = C_SEED; m_sr = C_SEED;
    end else begin
      if (acc) begin
        if (g != r) begin
          if (!m_fail) begin
            m_fidx  = m_vec;
            m_fdiff = g ^ r;
          end
          m_fail = 1;
          m_mism++;
        end
        m_vec++;
        m_sg = misr(m_sg, g);
        m_sr = misr(m_sr, r);
      end
      if (m_st == 1 && p) m_st = 2;
    end
    push_exp();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    push_exp();
    compare();
    @(posedge clk);
    #1;
    push_exp();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; in_valid = 0; golden = 0; revised = 0;
    model_reset();
    do_reset();

    // Tie-zero run of 100 vectors.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(0, 0, 1, 9'h000, 9'h000);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 9'h1FF, 9'h000);  // ignored in DONE

    // Single MISR feedback step.
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 9'h100, 9'h100);
    step(0, 0, 1, 9'h000, 9'h000);
    step(0, 1, 0, 0, 0);

    // First-failure capture with a later mismatch.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, 9'h000, (i == 5) ? 9'h004 : (i == 8) ? 9'h1FF : 9'h000);
    step(0, 1, 0, 0, 0);

    // Counter saturation on the 4-bit instance.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      logic [8:0] g;
      g = 9'($urandom_range(0, 511));
      step(0, 0, 1, g, g ^ 9'h001);
    end
    step(0, 1, 1, 9'h003, 9'h003);  // accepted in stop cycle

    // start+stop together in RUN, then stop with a vector.
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 9'h012, 9'h012);
    step(1, 1, 1, 9'h0AA, 9'h055);
    step(0, 1, 1, 9'h0F0, 9'h0F0);
    step(0, 0, 0, 0, 0);

    // Random mix of matches and mismatches.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      logic [8:0] g, r;
      g = 9'($urandom_range(0, 511));
      r = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : g;
      step(0, 0, ($urandom_range(0, 4) != 0), g, r);
    end
    step(0, 1, 0, 0, 0);

    // Reset mid-RUN aborts; valid vectors in IDLE are ignored.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 9'(i), 9'(i ^ 2));
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 9'h1A5, 9'h05A);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 9'h077, 9'h077);
    step(0, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
